// File: rtl/sine_pwm_dac.sv
// sine_pwm_dac: buffered sample-to-PWM converter that applies each new duty only at a period boundary
module sine_pwm_dac #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [SAMPLE_WIDTH-1:0]   sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      pwm_out,
  output logic                      period_start,
  output logic                      underrun
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [SAMPLE_WIDTH-1:0] LAST = {{(SAMPLE_WIDTH-1){1'b1}}, 1'b0};
  state_t state, state_next;
  logic [SAMPLE_WIDTH-1:0] counter, counter_next, duty, duty_next, pending, pending_next;
  logic [PRESCALE_WIDTH-1:0] prescaler, prescaler_next, prescale_q, prescale_q_next;
  logic pending_full, pending_full_next, tick, boundary, accept;
  assign sample_ready = !pending_full;
  always_comb begin
    state_next = enable ? RUN : IDLE;
    accept = sample_valid && !pending_full;
    tick = (state == RUN) && (prescaler == prescale_q);
    boundary = enable && ((state == IDLE) || (tick && (counter == LAST)));
    counter_next = (!enable || boundary) ? '0 : tick ? counter + 1'b1 : counter;
    prescaler_next = (!enable || boundary || tick) ? '0 : prescaler + 1'b1;
    prescale_q_next = boundary ? prescale : prescale_q;
    duty_next = (boundary && pending_full) ? pending : duty;
    pending_next = accept ? sample_in : pending;
    pending_full_next = (boundary && pending_full) ? 1'b0 : accept ? 1'b1 : pending_full;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      counter <= '0;
      prescaler <= '0;
      prescale_q <= '0;
      duty <= '0;
      pending <= '0;
      pending_full <= 1'b0;
      pwm_out <= 1'b0;
      period_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_next;
      counter <= counter_next;
      prescaler <= prescaler_next;
      prescale_q <= prescale_q_next;
      duty <= duty_next;
      pending <= pending_next;
      pending_full <= pending_full_next;
      pwm_out <= enable && (counter_next < duty_next);
      period_start <= boundary;
      underrun <= boundary && !pending_full;
    end
  end
endmodule

// File: tb/tb_sine_pwm_dac.sv
// tb_sine_pwm_dac: table-driven and scoreboard checks of per-period PWM high time, length and handshake
module tb_sine_pwm_dac;
  typedef struct {
    logic [7:0] sample;
    logic [7:0] ps;
    int hi;
    int len;
  } vec_t;
  typedef struct {
    int hi;
    int len;
  } exp_t;
  logic clock, reset, enable, sample_valid, sample_ready, pwm_out, period_start, underrun;
  logic [7:0] prescale, sample_in;
  int n_cmp, n_bad, hi_cnt, len_cnt, n_starts, n_under, u0;
  bit measuring;
  exp_t cur;
  exp_t exp_q[$];
  vec_t tab[6];
  logic [7:0] t3[3];
  sine_pwm_dac #(.SAMPLE_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .prescale(prescale),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_out(pwm_out),
    .period_start(period_start),
    .underrun(underrun)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask
  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (sample_ready) break;
    end
    if (k == 3000) timeout(name);
  endtask
  task automatic wait_starts(input int n, input string name);
    int t, k;
    @(posedge clock);
    t = n_starts + n;
    for (k = 0; k < 3000 * n; k++) begin
      if (n_starts >= t) break;
      @(posedge clock);
    end
    if (n_starts < t) timeout(name);
  endtask
  task automatic send(input logic [7:0] v, input logic [7:0] ps, input int hi, input int len);
    exp_t e;
    wait_ready("send_ready");
    e.hi = hi;
    e.len = len;
    prescale = ps;
    sample_in = v;
    sample_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clock);
    #1 sample_valid = 1'b0;
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      measuring = 1'b0;
      cur.hi = 0;
      cur.len = 255;
    end else if (!enable) begin
      measuring = 1'b0;
    end else if (period_start) begin
      if (measuring) begin
        check("period_high", hi_cnt, cur.hi);
        check("period_len", len_cnt, cur.len);
      end
      if (!underrun) begin
        check("ready_after_load", int'(sample_ready), 1);
        if (exp_q.size() == 0) timeout("unexpected_load");
        else cur = exp_q.pop_front();
      end
      measuring = 1'b1;
      hi_cnt = int'(pwm_out);
      len_cnt = 1;
    end else if (measuring) begin
      hi_cnt += int'(pwm_out);
      len_cnt++;
    end
    n_starts += int'(period_start);
    n_under += int'(underrun);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    reset = 1'b0;
    enable = 1'b1;
    sample_valid = 1'b1;
    sample_in = 8'hAA;
    prescale = 8'd0;
    tab = '{'{8'h00, 8'd0, 0, 255}, '{8'h80, 8'd0, 128, 255}, '{8'hFF, 8'd0, 255, 255},
            '{8'h80, 8'd3, 512, 1020}, '{8'h01, 8'd3, 4, 1020}, '{8'h55, 8'd0, 85, 255}};
    t3 = '{8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_ready", int'(sample_ready), 1);
      check("rst_start", int'(period_start), 0);
      check("rst_underrun", int'(underrun), 0);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    @(negedge clock);
    check("post_reset_ready", int'(sample_ready), 1);
    check("post_reset_start", int'(period_start), 0);
    for (int i = 0; i < 6; i++) begin
      send(tab[i].sample, tab[i].ps, tab[i].hi, tab[i].len);
      if (i == 0) enable = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      wait_ready("t3_ready");
      e.hi = int'(t3[i]);
      e.len = 255;
      sample_in = t3[i];
      sample_valid = 1'b1;
      exp_q.push_back(e);
      @(negedge clock);
      check("t3_ready_drop", int'(sample_ready), 0);
    end
    sample_valid = 1'b0;
    send(8'h40, 8'd0, 64, 255);
    @(posedge clock);
    u0 = n_under;
    wait_starts(2, "t4_starts");
    check("t4_underrun_once", n_under - u0, 1);
    wait_starts(1, "t4_hold");
    begin
      int k;
      for (k = 0; k < 300; k++) begin
        @(negedge clock);
        if (period_start) break;
      end
      if (k == 300) timeout("t6_sync");
    end
    repeat (20) @(negedge clock);
    send(8'hC0, 8'd0, 192, 255);
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("pwm_before_drop", int'(pwm_out), 1);
    @(posedge clock);
    #1 enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("pwm_idle", int'(pwm_out), 0);
    check("pending_kept", int'(sample_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("idle_pwm", int'(pwm_out), 0);
      check("idle_start", int'(period_start), 0);
    end
    @(posedge clock);
    #1 enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("restart_start", int'(period_start), 1);
    check("restart_load", int'(underrun), 0);
    repeat (254) @(negedge clock);
    begin
      exp_t e;
      e.hi = 8'h33;
      e.len = 255;
      check("collision_ready", int'(sample_ready), 1);
      sample_in = 8'h33;
      sample_valid = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1 sample_valid = 1'b0;
    @(negedge clock);
    check("collision_start", int'(period_start), 1);
    check("collision_underrun", int'(underrun), 1);
    check("collision_captured", int'(sample_ready), 0);
    wait_starts(2, "t6_final");
    check("queue_drained", int'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
